load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access stage of the RV32I core. It sits directly downstream of the ALU: it takes the ALU `Result` as the effective address, plus rs2 data and funct3 from decode. It drives a request/grant/response data-memory port, returns sign- or zero-extended load data to writeback, and stalls the core while an access is outstanding. It also detects misaligned accesses, illegal access encodings, and bus timeouts.

## Interface
- TIMEOUT, 64, cycles allowed in REQ+WAIT before an access is aborted with AccessFault (legal range 2..255)

- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- MemRead  in  1  load request from control unit; held high by the core while Stall=1
- MemWrite  in  1  store request from control unit; held high while Stall=1
- Funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResult  in  32  effective byte address from the ALU
- WriteData  in  32  store data (rs2)
- ReadData  out  32  extended load data; valid when Done=1 for a load
- Done  out  1  one-cycle completion pulse
- Stall  out  1  core must hold PC and pipeline inputs
- MisalignedLoad  out  1  fault flag, qualified by Done
- MisalignedStore  out  1  fault flag, qualified by Done
- AccessFault  out  1  illegal encoding or timeout, qualified by Done
- DMemReq  out  1  memory request
- DMemWe  out  1  1 = write
- DMemAddr  out  32  word-aligned address ({addr[31:2],2'b00})
- DMemWData  out  32  lane-replicated store data
- DMemBE  out  4  byte enables
- DMemGnt  in  1  memory accepted request
- DMemRValid  in  1  read data valid
- DMemRData  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE**, when MemRead|MemWrite:
  - Latch address, Funct3, WriteData, and direction.
  - Illegal cases go to DONE with AccessFault=1 and no bus request:
    - MemRead&MemWrite both high.
    - Load with Funct3 ∈ {011,110,111}.
    - Store with Funct3 ≥ 011.
  - Misaligned cases go to DONE with MisalignedLoad or MisalignedStore=1 and no bus request:
    - H/HU with addr[0]=1.
    - W with addr[1:0]≠0.
  - Otherwise go to REQ and clear the timeout counter.
- **REQ**:
  - DMemReq=1 with latched DMemWe, DMemAddr, DMemWData, DMemBE.
  - On DMemGnt: a store goes to DONE; a load goes to WAIT.
- **WAIT**: on DMemRValid, capture the extended DMemRData into ReadData and go to DONE.
- **DONE**: Done=1 with flags valid. Always returns to IDLE.
- Byte enables and store data:
  - B: DMemBE = 1<<addr[1:0], DMemWData = {4{WriteData[7:0]}}.
  - H: DMemBE = addr[1] ? 1100 : 0011, DMemWData = {2{WriteData[15:0]}}.
  - W: DMemBE = 1111, DMemWData = WriteData.
  - Loads drive the same DMemBE pattern.
- Load extraction:
  - Shift DMemRData right by 8*addr[1:0].
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W passes through.
- Timeout:
  - Counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 with no Gnt (REQ) or RValid (WAIT), go to DONE with AccessFault=1 and drop DMemReq.
  - A completion event in the same cycle wins over timeout.
- ReadData holds its last value until the next successful load. Fault flags are 0 outside DONE.
- DMemRValid or DMemGnt arriving in IDLE or DONE is ignored.

## Timing
- Reset values:
  - state=IDLE.
  - ReadData=0, DMemAddr=0, DMemWData=0, DMemBE=0.
  - Done=0, DMemReq=0, DMemWe=0, all fault flags=0.
- Stall (combinational) = (IDLE & (MemRead|MemWrite)) | REQ | WAIT. Stall is 0 in DONE, so the core commits on that edge.
- DMemReq, DMemWe, DMemAddr, DMemWData, DMemBE are registered and stable for all of REQ. DMemReq=0 in all other states.
- Memory contract: DMemRValid comes at least 1 cycle after Gnt and is sampled only in WAIT.
- Best-case latency from the acceptance cycle (IDLE with request) to Done:
  - Store: 2 cycles (REQ with Gnt, then DONE).
  - Load: 3 cycles.
  - Fault detected in IDLE: 1 cycle.
- Back-to-back accesses: DONE→IDLE is mandatory, so the next access is accepted the cycle after Done.
- Asserting rst mid-access immediately returns to IDLE and drops DMemReq. No Done is produced, and any late response is ignored.

## Test plan
- **LW**: addr 0x100, Gnt in REQ, RValid=0xDEADBEEF one cycle later → DMemAddr=0x100, DMemBE=1111, Done 3 cycles after accept, ReadData=0xDEADBEEF.
- **LB / LBU**: addr 0x103, RData=0x80FF_FF00 → LB ReadData=0xFFFFFF80; LBU ReadData=0x00000080.
- **SH**: addr 0x202, WriteData=0x1234ABCD → DMemAddr=0x200, DMemBE=1100, DMemWData=0xABCDABCD, DMemWe=1, Done 2 cycles after accept.
- **Misaligned and illegal**:
  - LW at 0x101 → MisalignedLoad=1 with Done next cycle, DMemReq never asserted.
  - Store with Funct3=011 → AccessFault=1.
- **Timeout**: LW with DMemGnt held 0, TIMEOUT=64 → AccessFault with Done after 64 REQ cycles, DMemReq low after abort.
- **Reset mid-access**: rst asserted in WAIT → DMemReq=0, all outputs at reset values asynchronously. A late RValid=0x55555555 after reset leaves ReadData=0 and Done=0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I data-memory access stage with alignment, encoding and timeout faults
// Ports: core side MemRead/MemWrite/Funct3/ALUResult/WriteData in, ReadData/Done/Stall and
//        MisalignedLoad/MisalignedStore/AccessFault out; memory side DMemReq/DMemWe/DMemAddr/
//        DMemWData/DMemBE out, DMemGnt/DMemRValid/DMemRData in.
module load_store_unit #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Done,
   output logic        Stall,
   output logic        MisalignedLoad,
   output logic        MisalignedStore,
   output logic        AccessFault,
   output logic        DMemReq,
   output logic        DMemWe,
   output logic [31:0] DMemAddr,
   output logic [31:0] DMemWData,
   output logic [3:0]  DMemBE,
   input  logic        DMemGnt,
   input  logic        DMemRValid,
   input  logic [31:0] DMemRData
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        req_q, req_d, we_q, we_d, af_q, af_d, ml_q, ml_d, ms_q, ms_d;
   logic        acc, ill, mis, tmo;
   logic [3:0]  be_new;
   logic [31:0] wd_new, sh, ext;
   always_comb begin
      acc = MemRead | MemWrite;
      ill = (MemRead & MemWrite) | (MemRead & (Funct3 == 3'b011 | Funct3[2:1] == 2'b11))
          | (MemWrite & Funct3 >= 3'b011);
      // illegal encodings take priority so only one fault flag is ever raised
      mis = !ill & ((Funct3[1:0] == 2'b01 & ALUResult[0]) | (Funct3[1:0] == 2'b10 & ALUResult[1:0] != 2'b00));
      be_new = Funct3[1:0] == 2'b00 ? 4'b0001 << ALUResult[1:0]
             : Funct3[1:0] == 2'b01 ? (ALUResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wd_new = Funct3[1:0] == 2'b00 ? {4{WriteData[7:0]}}
             : Funct3[1:0] == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
      tmo = cnt_q == 8'(TIMEOUT - 1);
      sh = DMemRData >> {off_q, 3'b000};
      ext = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]}
          : f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]}
          : f3_q == 3'b100 ? {24'd0, sh[7:0]}
          : f3_q == 3'b101 ? {16'd0, sh[15:0]} : sh;
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      off_d = off_q;
      f3_d = f3_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      be_d = be_q;
      req_d = req_q;
      we_d = we_q;
      rdata_d = rdata_q;
      af_d = af_q;
      ml_d = ml_q;
      ms_d = ms_q;
      case (state_q)
         IDLE: if (acc) begin
            off_d = ALUResult[1:0];
            f3_d = Funct3;
            addr_d = {ALUResult[31:2], 2'b00};
            wdata_d = wd_new;
            be_d = be_new;
            we_d = MemWrite;
            af_d = ill;
            ml_d = mis & MemRead;
            ms_d = mis & MemWrite;
            req_d = !(ill | mis);
            cnt_d = 8'd0;
            state_d = (ill | mis) ? DONE : REQ;
         end
         REQ: begin
            cnt_d = cnt_q + 8'd1;
            // a grant in the timeout cycle still completes the access
            if (DMemGnt | tmo) begin
               req_d = 1'b0;
               af_d = !DMemGnt;
               state_d = (DMemGnt & !we_q) ? WAIT : DONE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (DMemRValid | tmo) begin
               af_d = !DMemRValid;
               rdata_d = DMemRValid ? ext : rdata_q;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= 8'd0;
         off_q <= 2'd0;
         f3_q <= 3'd0;
         addr_q <= 32'd0;
         wdata_q <= 32'd0;
         be_q <= 4'd0;
         req_q <= 1'b0;
         we_q <= 1'b0;
         rdata_q <= 32'd0;
         af_q <= 1'b0;
         ml_q <= 1'b0;
         ms_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         off_q <= off_d;
         f3_q <= f3_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         be_q <= be_d;
         req_q <= req_d;
         we_q <= we_d;
         rdata_q <= rdata_d;
         af_q <= af_d;
         ml_q <= ml_d;
         ms_q <= ms_d;
      end
   end
   assign Done = state_q == DONE;
   assign Stall = (state_q == IDLE & acc) | state_q == REQ | state_q == WAIT;
   assign MisalignedLoad = ml_q & Done;
   assign MisalignedStore = ms_q & Done;
   assign AccessFault = af_q & Done;
   assign ReadData = rdata_q;
   assign DMemReq = req_q;
   assign DMemWe = we_q;
   assign DMemAddr = addr_q;
   assign DMemWData = wdata_q;
   assign DMemBE = be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven and hand-sequenced checks of the data-memory access stage
module tb_load_store_unit;
   logic clk = 1'b0, rst = 1'b1;
   logic MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0] Funct3 = 3'd0;
   logic [31:0] ALUResult = 32'd0, WriteData = 32'd0;
   logic DMemGnt = 1'b0, DMemRValid = 1'b0;
   logic [31:0] DMemRData = 32'd0;
   logic [31:0] ReadData, DMemAddr, DMemWData;
   logic [3:0] DMemBE;
   logic Done, Stall, MisalignedLoad, MisalignedStore, AccessFault, DMemReq, DMemWe;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
      .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Done(Done),
      .Stall(Stall), .MisalignedLoad(MisalignedLoad), .MisalignedStore(MisalignedStore),
      .AccessFault(AccessFault), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
      .DMemWData(DMemWData), .DMemBE(DMemBE), .DMemGnt(DMemGnt), .DMemRValid(DMemRValid),
      .DMemRData(DMemRData)
   );

   typedef struct {
      logic rd, wr;
      logic [2:0] f3;
      logic [31:0] addr, wdata, rdata, exp_rd, exp_addr, exp_wdata;
      logic [3:0] exp_be;
      int lat;
      logic ml, ms, af;
   } vec_t;
   vec_t v[15];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int i, input vec_t t);
      int cyc;
      bit saw, fin;
      MemRead = t.rd; MemWrite = t.wr; Funct3 = t.f3; ALUResult = t.addr; WriteData = t.wdata;
      #1;
      chk($sformatf("v%0d stall_accept", i), 32'(Stall), 32'd1);
      saw = 0; fin = 0; cyc = 0;
      for (int k = 1; k <= 200 && !fin; k++) begin
         tick();
         cyc = k;
         DMemGnt = 0; DMemRValid = 0; DMemRData = 0;
         if (Done) fin = 1;
         else if (DMemReq) begin
            if (!saw) begin
               chk($sformatf("v%0d addr", i), DMemAddr, t.exp_addr);
               chk($sformatf("v%0d be", i), 32'(DMemBE), 32'(t.exp_be));
               chk($sformatf("v%0d wdata", i), DMemWData, t.exp_wdata);
               chk($sformatf("v%0d we", i), 32'(DMemWe), 32'(t.wr));
            end
            saw = 1;
            DMemGnt = 1;
         end else if (saw) begin
            DMemRValid = 1;
            DMemRData = t.rdata;
         end
      end
      chk($sformatf("v%0d done_seen", i), 32'(fin), 32'd1);
      chk($sformatf("v%0d latency", i), 32'(cyc), 32'(t.lat));
      chk($sformatf("v%0d req_seen", i), 32'(saw), 32'(t.lat > 1));
      chk($sformatf("v%0d flags", i), {29'd0, MisalignedLoad, MisalignedStore, AccessFault},
          {29'd0, t.ml, t.ms, t.af});
      chk($sformatf("v%0d stall_done", i), 32'(Stall), 32'd0);
      chk($sformatf("v%0d rdata", i), ReadData, t.exp_rd);
      MemRead = 0; MemWrite = 0;
      tick();
      chk($sformatf("v%0d done_pulse", i), 32'(Done), 32'd0);
   endtask

   task automatic bus_hold(input logic wr, input int gnt_at, output int cyc, output int nreq);
      bit fin;
      MemRead = !wr; MemWrite = wr; Funct3 = 3'b010; ALUResult = 32'h100; WriteData = 32'h1;
      fin = 0; cyc = 0; nreq = 0;
      for (int k = 1; k <= 200 && !fin; k++) begin
         tick();
         cyc = k;
         DMemGnt = 0;
         if (Done) fin = 1;
         else if (DMemReq) begin
            nreq++;
            DMemGnt = (nreq == gnt_at);
         end
      end
   endtask

   initial begin
      int cyc, nreq;
      v[0]  = '{1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 0, 4'hF, 3, 0, 0, 0};
      v[1]  = '{1, 0, 3'b000, 32'h103, 0, 32'h80FFFF00, 32'hFFFFFF80, 32'h100, 0, 4'h8, 3, 0, 0, 0};
      v[2]  = '{1, 0, 3'b100, 32'h103, 0, 32'h80FFFF00, 32'h00000080, 32'h100, 0, 4'h8, 3, 0, 0, 0};
      v[3]  = '{0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 32'h00000080, 32'h200, 32'hABCDABCD, 4'hC, 2, 0, 0, 0};
      v[4]  = '{1, 0, 3'b001, 32'h102, 0, 32'h87651234, 32'hFFFF8765, 32'h100, 0, 4'hC, 3, 0, 0, 0};
      v[5]  = '{1, 0, 3'b101, 32'h100, 0, 32'h8765F234, 32'h0000F234, 32'h100, 0, 4'h3, 3, 0, 0, 0};
      v[6]  = '{0, 1, 3'b000, 32'h301, 32'h000000A5, 0, 32'h0000F234, 32'h300, 32'hA5A5A5A5, 4'h2, 2, 0, 0, 0};
      v[7]  = '{0, 1, 3'b010, 32'h304, 32'hCAFEF00D, 0, 32'h0000F234, 32'h304, 32'hCAFEF00D, 4'hF, 2, 0, 0, 0};
      v[8]  = '{1, 0, 3'b000, 32'h102, 0, 32'h007F0000, 32'h0000007F, 32'h100, 0, 4'h4, 3, 0, 0, 0};
      v[9]  = '{1, 0, 3'b010, 32'h101, 0, 0, 32'h0000007F, 0, 0, 4'h0, 1, 1, 0, 0};
      v[10] = '{0, 1, 3'b001, 32'h203, 32'h5, 0, 32'h0000007F, 0, 0, 4'h0, 1, 0, 1, 0};
      v[11] = '{0, 1, 3'b011, 32'h0, 32'h5, 0, 32'h0000007F, 0, 0, 4'h0, 1, 0, 0, 1};
      v[12] = '{1, 0, 3'b110, 32'h0, 0, 0, 32'h0000007F, 0, 0, 4'h0, 1, 0, 0, 1};
      v[13] = '{1, 1, 3'b010, 32'h0, 0, 0, 32'h0000007F, 0, 0, 4'h0, 1, 0, 0, 1};
      v[14] = '{1, 0, 3'b001, 32'h101, 0, 0, 32'h0000007F, 0, 0, 4'h0, 1, 1, 0, 0};
      #12;
      chk("rst_outs", {ReadData ^ DMemAddr ^ DMemWData, 28'd0, DMemBE},
          {32'd0, 28'd0, 4'd0});
      chk("rst_bits", {25'd0, Done, DMemReq, DMemWe, MisalignedLoad, MisalignedStore, AccessFault, Stall}, 32'd0);
      chk("rst_rdata", ReadData, 32'd0);
      rst = 0;
      tick();
      for (int i = 0; i < 15; i++) run(i, v[i]);
      // load with no grant: aborts after TIMEOUT REQ cycles
      bus_hold(1'b0, 0, cyc, nreq);
      chk("tmo_latency", 32'(cyc), 32'd65);
      chk("tmo_req_cycles", 32'(nreq), 32'd64);
      chk("tmo_af", 32'(AccessFault), 32'd1);
      chk("tmo_req_low", 32'(DMemReq), 32'd0);
      chk("tmo_rdata", ReadData, 32'h0000007F);
      MemRead = 0; MemWrite = 0;
      tick();
      // grant arriving in the last allowed cycle wins over the timeout
      bus_hold(1'b1, 64, cyc, nreq);
      chk("edge_latency", 32'(cyc), 32'd65);
      chk("edge_af", 32'(AccessFault), 32'd0);
      MemRead = 0; MemWrite = 0;
      DMemGnt = 0;
      tick();
      // reset while waiting for read data
      MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h100;
      tick();
      chk("rstmid_req", 32'(DMemReq), 32'd1);
      DMemGnt = 1;
      tick();
      DMemGnt = 0;
      chk("rstmid_wait_stall", 32'(Stall), 32'd1);
      #3;
      MemRead = 0;
      rst = 1;
      #1;
      chk("rstmid_addr", DMemAddr, 32'd0);
      chk("rstmid_be", 32'(DMemBE), 32'd0);
      chk("rstmid_rdata", ReadData, 32'd0);
      chk("rstmid_bits", {28'd0, DMemReq, Done, Stall, DMemWe}, 32'd0);
      tick();
      rst = 0;
      DMemRValid = 1; DMemRData = 32'h55555555; DMemGnt = 1;
      tick();
      chk("late_done1", 32'(Done), 32'd0);
      tick();
      chk("late_done2", 32'(Done), 32'd0);
      chk("late_rdata", ReadData, 32'd0);
      chk("late_req", 32'(DMemReq), 32'd0);
      DMemRValid = 0; DMemGnt = 0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
